// File: rtl/srq_burst_drain.sv
`default_nettype none
// ============================================================================
//  Module   : srq_burst_drain
//  Purpose  : Consumer end of the shift-register queue. Pops one WIDTH-bit
//             word from the queue tail and serializes it, LSB slice first,
//             into BEATS = WIDTH/BEAT_W beats on a valid/ready beat bus.
//             Back-to-back words stream with no bubble; a synchronous flush
//             drops the held word and returns to IDLE.
//  Ports    :
//    clk          in   clock, rising edge
//    rst          in   asynchronous active-low reset
//    q_out_valid  in   queue tail holds a valid word
//    q_data_out   in   queue tail word [WIDTH]
//    q_pop        out  one-cycle pop strobe to the queue
//    flush        in   synchronous abort
//    beat_valid   out  beat_data valid
//    beat_data    out  current beat [BEAT_W]
//    beat_last    out  final beat of the word
//    beat_ready   in   downstream accepts the beat
//    busy         out  high while a word is being sent
//    word_cnt     out  words fully drained [CNT_W], wraps
//  Revision : 1.0  initial release
// ============================================================================
module srq_burst_drain #(
  parameter int WIDTH  = 1024,
  parameter int BEAT_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_out_valid,
  input  logic [WIDTH-1:0]  q_data_out,
  output logic              q_pop,
  input  logic              flush,
  output logic              beat_valid,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_last,
  input  logic              beat_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEATS = WIDTH / BEAT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_w;
  logic             accept_w;
  logic             last_w;

  // Hold register viewed as an array of beats; element 0 is the LSB slice.
  logic [BEATS-1:0][BEAT_W-1:0] beats_w;
  assign beats_w = hold_q;

  assign beat_valid = (state_q == S_SEND);
  assign busy       = (state_q == S_SEND);
  assign last_w     = (idx_q == LAST_IDX);
  assign beat_last  = beat_valid & last_w;
  assign beat_data  = beats_w[idx_q];
  assign accept_w   = beat_valid & beat_ready;
  assign word_cnt   = cnt_q;

  // The pop strobe is combinational, so it is gated by reset to keep every
  // output low while reset is asserted even if the queue reports valid.
  assign q_pop = rst & pop_w;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    pop_w   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (q_out_valid && !flush) begin
          pop_w   = 1'b1;
          hold_d  = q_data_out;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (accept_w) begin
          if (last_w) begin
            cnt_d = cnt_q + CNT_W'(1);
            // Refill in the same cycle as the last accept: no bubble.
            if (q_out_valid && !flush) begin
              pop_w  = 1'b1;
              hold_d = q_data_out;
              idx_d  = '0;
            end else begin
              idx_d   = '0;
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    // Flush overrides the next state; an accept in this cycle still counts.
    if (flush) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_srq_burst_drain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_srq_burst_drain
//  Purpose  : Directed scoreboard bench for srq_burst_drain. Instance 0 uses
//             the default 1024/128 geometry; instance 1 uses a single-beat
//             geometry with a 2-bit word counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_srq_burst_drain;

  localparam int W0 = 1024;
  localparam int B0 = 128;
  localparam int C0 = 16;
  localparam int N0 = W0 / B0;
  localparam int W1 = 32;
  localparam int B1 = 32;
  localparam int C1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          qv0, pop0, flush0, bv0, last0, ready0, busy0;
  logic [W0-1:0] qd0;
  logic [B0-1:0] bd0;
  logic [C0-1:0] cnt0;

  logic          qv1, pop1, flush1, bv1, last1, ready1, busy1;
  logic [W1-1:0] qd1;
  logic [B1-1:0] bd1;
  logic [C1-1:0] cnt1;

  srq_burst_drain #(.WIDTH(W0), .BEAT_W(B0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst(rst), .q_out_valid(qv0), .q_data_out(qd0), .q_pop(pop0),
    .flush(flush0), .beat_valid(bv0), .beat_data(bd0), .beat_last(last0),
    .beat_ready(ready0), .busy(busy0), .word_cnt(cnt0)
  );

  srq_burst_drain #(.WIDTH(W1), .BEAT_W(B1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst(rst), .q_out_valid(qv1), .q_data_out(qd1), .q_pop(pop1),
    .flush(flush1), .beat_valid(bv1), .beat_data(bd1), .beat_last(last1),
    .beat_ready(ready1), .busy(busy1), .word_cnt(cnt1)
  );

  int errors = 0;
  int checks = 0;

  // Queue model (source) and expected-beat scoreboard for each instance.
  logic [W0-1:0] src0[$];
  logic [W1-1:0] src1[$];
  logic [B0-1:0] e0d[$];
  logic          e0l[$];
  logic [B1-1:0] e1d[$];
  logic          e1l[$];

  logic s_pop0, s_bv0, s_last0, s_pop1, s_bv1, s_last1;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W0-1:0] rword0();
    logic [W0-1:0] r;
    for (int i = 0; i < W0 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_src();
    qv0 = (src0.size() > 0);
    qd0 = (src0.size() > 0) ? src0[0] : '0;
    qv1 = (src1.size() > 0);
    qd1 = (src1.size() > 0) ? src1[0] : '0;
  endtask

  task automatic push0(input logic [W0-1:0] w);
    src0.push_back(w);
    for (int k = 0; k < N0; k++) begin
      e0d.push_back(w[k*B0 +: B0]);
      e0l.push_back(k == N0 - 1);
    end
    drive_src();
  endtask

  task automatic push1(input logic [W1-1:0] w);
    src1.push_back(w);
    e1d.push_back(w);
    e1l.push_back(1'b1);
    drive_src();
  endtask

  // One clock: sample and score at the falling edge, then advance the queue
  // model just after the rising edge on which a pop was taken.
  task automatic tick();
    @(negedge clk);
    s_pop0 = pop0; s_bv0 = bv0; s_last0 = last0;
    s_pop1 = pop1; s_bv1 = bv1; s_last1 = last1;
    chk("pop0_only_when_valid", pop0 & ~qv0, 1'b0);
    chk("pop1_only_when_valid", pop1 & ~qv1, 1'b0);
    if (bv0) begin
      chk("beat0_expected", e0d.size() > 0, 1'b1);
      chk("busy0", busy0, 1'b1);
      if (e0d.size() > 0) begin
        chk("beat0_data", bd0, e0d[0]);
        chk("beat0_last", last0, e0l[0]);
        if (ready0) begin
          void'(e0d.pop_front());
          void'(e0l.pop_front());
        end
      end
    end
    if (bv1) begin
      chk("beat1_expected", e1d.size() > 0, 1'b1);
      if (e1d.size() > 0) begin
        chk("beat1_data", bd1, e1d[0]);
        chk("beat1_last", last1, e1l[0]);
        if (ready1) begin
          void'(e1d.pop_front());
          void'(e1l.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (s_pop0 && src0.size() > 0) void'(src0.pop_front());
    if (s_pop1 && src1.size() > 0) void'(src1.pop_front());
    drive_src();
  endtask

  initial begin
    rst = 1'b0;
    flush0 = 1'b0; ready0 = 1'b1; flush1 = 1'b0; ready1 = 1'b1;
    drive_src();

    // Reset state
    tick();
    tick();
    chk("rst_bv0", bv0, 1'b0);
    chk("rst_pop0", pop0, 1'b0);
    chk("rst_data0", bd0, '0);
    chk("rst_last0", last0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_cnt0", cnt0, '0);
    chk("rst_cnt1", cnt1, '0);
    rst = 1'b1;
    tick();

    // Single word, ready held high: one-cycle latency, 8 consecutive beats
    push0(rword0());
    tick();
    chk("t1_pop", s_pop0, 1'b1);
    chk("t1_bv_at_pop", s_bv0, 1'b0);
    for (int i = 0; i < N0; i++) begin
      tick();
      chk("t1_bv", s_bv0, 1'b1);
      chk("t1_last", s_last0, i == N0 - 1);
    end
    tick();
    chk("t1_bv_after", s_bv0, 1'b0);
    chk("t1_cnt", cnt0, 16'd1);

    // Backpressure on burst cycles 3-5
    push0(rword0());
    tick();
    for (int i = 0; i < N0 + 3; i++) begin
      ready0 = !(i >= 2 && i <= 4);
      tick();
      chk("t2_bv", s_bv0, 1'b1);
    end
    ready0 = 1'b1;
    tick();
    chk("t2_bv_after", s_bv0, 1'b0);
    chk("t2_cnt", cnt0, 16'd2);
    chk("t2_drained", e0d.size(), 0);

    // Two queued words: 16 consecutive beats, second pop on first last accept
    push0(rword0());
    push0(rword0());
    tick();
    chk("t3_pop_first", s_pop0, 1'b1);
    for (int i = 0; i < 2 * N0; i++) begin
      tick();
      chk("t3_bv", s_bv0, 1'b1);
      chk("t3_pop", s_pop0, i == N0 - 1);
    end
    tick();
    chk("t3_bv_after", s_bv0, 1'b0);
    chk("t3_cnt", cnt0, 16'd4);

    // Flush on beat 4 of 8 with a second word waiting
    push0(rword0());
    tick();
    push0(rword0());
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_pop_mid", s_pop0, 1'b0);
    end
    flush0 = 1'b1;
    tick();
    chk("t4_no_pop_flush", s_pop0, 1'b0);
    flush0 = 1'b0;
    for (int i = 0; i < N0 - 4; i++) begin
      void'(e0d.pop_front());
      void'(e0l.pop_front());
    end
    tick();
    chk("t4_bv_after_flush", s_bv0, 1'b0);
    chk("t4_pop_next", s_pop0, 1'b1);
    chk("t4_cnt_unchanged", cnt0, 16'd4);
    for (int i = 0; i < N0; i++) begin
      tick();
      chk("t4_last", s_last0, i == N0 - 1);
    end
    tick();
    chk("t4_cnt", cnt0, 16'd5);

    // Asynchronous reset mid-burst
    push0(rword0());
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t5_bv", bv0, 1'b0);
    chk("t5_pop", pop0, 1'b0);
    chk("t5_data", bd0, '0);
    chk("t5_last", last0, 1'b0);
    chk("t5_busy", busy0, 1'b0);
    chk("t5_cnt", cnt0, '0);
    e0d.delete();
    e0l.delete();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_idle_after", s_bv0, 1'b0);
    end
    push0(rword0());
    tick();
    chk("t5_pop_after", s_pop0, 1'b1);
    for (int i = 0; i < N0; i++) tick();
    tick();
    chk("t5_cnt_after", cnt0, 16'd1);
    chk("t5_drained", e0d.size(), 0);

    // Single-beat geometry: three words, pops on consecutive cycles
    push1(32'hA5A5_0001);
    push1(32'h5A5A_0002);
    push1(32'hDEAD_0003);
    tick();
    chk("t6_pop0", s_pop1, 1'b1);
    chk("t6_bv0", s_bv1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_bv", s_bv1, 1'b1);
      chk("t6_last", s_last1, 1'b1);
      chk("t6_pop", s_pop1, i < 2);
    end
    tick();
    chk("t6_bv_after", s_bv1, 1'b0);
    chk("t6_cnt", cnt1, 2'd3);
    push1(32'h1234_5678);
    push1(32'h8765_4321);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_cnt_wrap", cnt1, 2'd1);
    chk("t6_drained", e1d.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
